fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 105 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time a burst of up to
// BURST_MAX words into a downstream FIFO, with one idle bubble between grants.
module fifo_wr_arbiter #(
  parameter int DATA_W    = 32,
  parameter int N_REQ     = 4,
  parameter int BURST_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wr,
  output logic [DATA_W-1:0]       fifo_data,
  output logic [1:0]              grant_id,
  output logic                    busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

  state_t      state, state_nxt;
  logic [1:0]  owner, owner_nxt;
  logic [1:0]  rr_ptr, rr_ptr_nxt;
  logic [3:0]  burst_cnt, burst_cnt_nxt;
  logic [2:0]  pick;
  logic        xfer;
  logic [DATA_W-1:0] words [N_REQ];

  // Returns {found, index} of the first valid requester at or above ptr, wrapping.
  function automatic logic [2:0] rr_pick(input logic [3:0] valid, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    idx = ptr;
    for (int k = 0; k < 4; k++) begin
      if (!res[2] && valid[idx]) res = {1'b1, idx};
      idx = idx + 2'd1;
    end
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++) words[i] = req_data[i*DATA_W +: DATA_W];
  end

  assign grant_id = owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 2'd0;
      rr_ptr    <= 2'd0;
      burst_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    req_ready     = '0;
    fifo_wr       = 1'b0;
    fifo_data     = '0;
    busy          = 1'b0;
    xfer          = 1'b0;
    pick          = rr_pick(req_valid, rr_ptr);
    case (state)
      IDLE: begin
        if (pick[2]) begin
          owner_nxt     = pick[1:0];
          burst_cnt_nxt = 4'd0;
          state_nxt     = GRANT;
        end
      end
      GRANT: begin
        busy             = 1'b1;
        req_ready[owner] = !fifo_full;
        fifo_data        = words[owner];
        xfer             = req_valid[owner] && !fifo_full;
        fifo_wr          = xfer;
        if (xfer) burst_cnt_nxt = burst_cnt + 4'd1;
        // A full FIFO with a still-valid owner stalls indefinitely; only a
        // dropped valid or the last beat of the burst gives the grant up.
        if (!req_valid[owner] || (xfer && burst_cnt == BURST_LAST)) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = owner + 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: BURST_MAX=4 instance plus a BURST_MAX=1 instance.
module tb_fifo_wr_arbiter;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [3:0]      req_valid, req_valid1;
  logic [4*DW-1:0] req_data;
  logic            fifo_full;
  logic [3:0]      req_ready, req_ready1;
  logic            fifo_wr, fifo_wr1;
  logic [DW-1:0]   fifo_data, fifo_data1;
  logic [1:0]      grant_id, grant_id1;
  logic            busy, busy1;
  logic [DW-1:0]   word [4];

  int total = 0;
  int bad   = 0;

  fifo_wr_arbiter #(.DATA_W(DW), .N_REQ(4), .BURST_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
    .fifo_data(fifo_data), .grant_id(grant_id), .busy(busy)
  );

  fifo_wr_arbiter #(.DATA_W(DW), .N_REQ(4), .BURST_MAX(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_data(req_data),
    .req_ready(req_ready1), .fifo_full(fifo_full), .fifo_wr(fifo_wr1),
    .fifo_data(fifo_data1), .grant_id(grant_id1), .busy(busy1)
  );

  initial begin
    word[0] = 32'hC0DE_0A00;
    word[1] = 32'h1234_5671;
    word[2] = 32'hBEEF_2222;
    word[3] = 32'h5A5A_3333;
  end
  assign req_data = {word[3], word[2], word[1], word[0]};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid  = 4'b0000;
    req_valid1 = 4'b0000;
    fifo_full  = 1'b0;
    rst_n      = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (busy !== 1'b0 || fifo_wr !== 1'b0 || req_ready !== 4'b0 || fifo_data !== '0 || grant_id !== 2'd0) begin
      bad++;
      $display("FAIL reset_async got busy=%b wr=%b rdy=%b data=%h gid=%0d exp all zero", busy, fifo_wr, req_ready, fifo_data, grant_id);
    end
    cyc();
    total++;
    if (busy1 !== 1'b0 || fifo_wr1 !== 1'b0 || req_ready1 !== 4'b0 || fifo_data1 !== '0 || grant_id1 !== 2'd0) begin
      bad++;
      $display("FAIL reset_clocked got busy=%b wr=%b rdy=%b data=%h gid=%0d exp all zero", busy1, fifo_wr1, req_ready1, fifo_data1, grant_id1);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    logic [1:0] last;
    int nk;
    do_reset();
    req_valid = 4'b1010;
    last = 2'd0;
    for (int b = 0; b < 3; b++) begin
      g  = (b == 1) ? 2'd3 : 2'd1;
      nk = (b == 2) ? 1 : 4;
      #1;
      total++;
      if (busy !== 1'b0 || fifo_wr !== 1'b0 || fifo_data !== '0 || req_ready !== 4'b0 || grant_id !== last) begin
        bad++;
        $display("FAIL rr_bubble b=%0d got busy=%b wr=%b data=%h rdy=%b gid=%0d exp 0/0/0/0 gid=%0d", b, busy, fifo_wr, fifo_data, req_ready, grant_id, last);
      end
      cyc();
      for (int k = 0; k < nk; k++) begin
        #1;
        total++;
        if (busy !== 1'b1 || fifo_wr !== 1'b1 || grant_id !== g || fifo_data !== word[g] || req_ready !== (4'b0001 << g)) begin
          bad++;
          $display("FAIL rr_xfer b=%0d k=%0d got busy=%b wr=%b gid=%0d data=%h rdy=%b exp gid=%0d data=%h", b, k, busy, fifo_wr, grant_id, fifo_data, req_ready, g, word[g]);
        end
        cyc();
      end
      last = g;
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_valid_drop();
    do_reset();
    req_valid = 4'b0100;
    #1;
    total++;
    if (busy !== 1'b0 || fifo_wr !== 1'b0) begin
      bad++;
      $display("FAIL drop_idle got busy=%b wr=%b exp 0 0", busy, fifo_wr);
    end
    cyc();
    for (int k = 0; k < 2; k++) begin
      #1;
      total++;
      if (fifo_wr !== 1'b1 || grant_id !== 2'd2 || fifo_data !== word[2] || req_ready !== 4'b0100) begin
        bad++;
        $display("FAIL drop_xfer k=%0d got wr=%b gid=%0d data=%h rdy=%b exp 1 2 %h 0100", k, fifo_wr, grant_id, fifo_data, req_ready, word[2]);
      end
      cyc();
    end
    req_valid = 4'b0000;
    #1;
    total++;
    if (busy !== 1'b1 || fifo_wr !== 1'b0 || req_ready !== 4'b0100 || grant_id !== 2'd2) begin
      bad++;
      $display("FAIL drop_release_cycle got busy=%b wr=%b rdy=%b gid=%0d exp 1 0 0100 2", busy, fifo_wr, req_ready, grant_id);
    end
    cyc();
    req_valid = 4'b1111;
    #1;
    total++;
    if (busy !== 1'b0 || fifo_wr !== 1'b0 || grant_id !== 2'd2) begin
      bad++;
      $display("FAIL drop_bubble got busy=%b wr=%b gid=%0d exp 0 0 2", busy, fifo_wr, grant_id);
    end
    cyc();
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (fifo_wr !== 1'b1 || grant_id !== 2'd3 || fifo_data !== word[3] || req_ready !== 4'b1000) begin
        bad++;
        $display("FAIL drop_next_xfer k=%0d got wr=%b gid=%0d data=%h rdy=%b exp 1 3 %h 1000", k, fifo_wr, grant_id, fifo_data, req_ready, word[3]);
      end
      cyc();
    end
    #1;
    total++;
    if (busy !== 1'b0 || fifo_wr !== 1'b0) begin
      bad++;
      $display("FAIL drop_next_end got busy=%b wr=%b exp 0 0", busy, fifo_wr);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_fifo_full();
    do_reset();
    req_valid = 4'b0001;
    cyc();
    #1;
    total++;
    if (fifo_wr !== 1'b1 || grant_id !== 2'd0 || fifo_data !== word[0]) begin
      bad++;
      $display("FAIL full_first got wr=%b gid=%0d data=%h exp 1 0 %h", fifo_wr, grant_id, fifo_data, word[0]);
    end
    cyc();
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (busy !== 1'b1 || fifo_wr !== 1'b0 || req_ready !== 4'b0 || grant_id !== 2'd0 || fifo_data !== word[0]) begin
        bad++;
        $display("FAIL full_stall k=%0d got busy=%b wr=%b rdy=%b gid=%0d data=%h exp 1 0 0000 0 %h", k, busy, fifo_wr, req_ready, grant_id, fifo_data, word[0]);
      end
      cyc();
    end
    fifo_full = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (fifo_wr !== 1'b1 || req_ready !== 4'b0001 || grant_id !== 2'd0) begin
        bad++;
        $display("FAIL full_resume k=%0d got wr=%b rdy=%b gid=%0d exp 1 0001 0", k, fifo_wr, req_ready, grant_id);
      end
      cyc();
    end
    #1;
    total++;
    if (busy !== 1'b0 || fifo_wr !== 1'b0) begin
      bad++;
      $display("FAIL full_end got busy=%b wr=%b exp 0 0", busy, fifo_wr);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_all_valid();
    int writes;
    logic [1:0] g;
    do_reset();
    req_valid = 4'b1111;
    writes = 0;
    for (int b = 0; b < 4; b++) begin
      g = 2'(b);
      cyc();
      for (int k = 0; k < 4; k++) begin
        #1;
        if (fifo_wr === 1'b1) writes++;
        total++;
        if (grant_id !== g || fifo_data !== word[g] || req_ready !== (4'b0001 << g) || fifo_wr !== 1'b1) begin
          bad++;
          $display("FAIL all_xfer b=%0d k=%0d got gid=%0d data=%h rdy=%b wr=%b exp gid=%0d data=%h", b, k, grant_id, fifo_data, req_ready, fifo_wr, g, word[g]);
        end
        cyc();
      end
    end
    total++;
    if (writes !== 16) begin
      bad++;
      $display("FAIL all_write_count got=%0d exp=16", writes);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_mid_reset();
    do_reset();
    req_valid = 4'b0100;
    cyc();
    #1;
    total++;
    if (fifo_wr !== 1'b1 || grant_id !== 2'd2) begin
      bad++;
      $display("FAIL mrst_first got wr=%b gid=%0d exp 1 2", fifo_wr, grant_id);
    end
    cyc();
    #1;
    total++;
    if (fifo_wr !== 1'b1 || grant_id !== 2'd2) begin
      bad++;
      $display("FAIL mrst_second got wr=%b gid=%0d exp 1 2", fifo_wr, grant_id);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || fifo_wr !== 1'b0 || req_ready !== 4'b0 || fifo_data !== '0 || grant_id !== 2'd0) begin
      bad++;
      $display("FAIL mrst_async got busy=%b wr=%b rdy=%b data=%h gid=%0d exp all zero", busy, fifo_wr, req_ready, fifo_data, grant_id);
    end
    cyc();
    total++;
    if (fifo_wr !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mrst_held got wr=%b busy=%b exp 0 0", fifo_wr, busy);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || fifo_wr !== 1'b0) begin
      bad++;
      $display("FAIL mrst_idle got busy=%b wr=%b exp 0 0", busy, fifo_wr);
    end
    cyc();
    #1;
    total++;
    if (busy !== 1'b1 || fifo_wr !== 1'b1 || grant_id !== 2'd2 || fifo_data !== word[2]) begin
      bad++;
      $display("FAIL mrst_regrant got busy=%b wr=%b gid=%0d data=%h exp 1 1 2 %h", busy, fifo_wr, grant_id, fifo_data, word[2]);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_burst_one();
    logic [1:0] g;
    do_reset();
    req_valid1 = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      #1;
      total++;
      if (c % 2 == 0) begin
        if (busy1 !== 1'b0 || fifo_wr1 !== 1'b0) begin
          bad++;
          $display("FAIL b1_bubble c=%0d got busy=%b wr=%b exp 0 0", c, busy1, fifo_wr1);
        end
      end else begin
        g = (c == 1 || c == 5) ? 2'd0 : 2'd1;
        if (fifo_wr1 !== 1'b1 || grant_id1 !== g || fifo_data1 !== word[g] || req_ready1 !== (4'b0001 << g)) begin
          bad++;
          $display("FAIL b1_xfer c=%0d got wr=%b gid=%0d data=%h rdy=%b exp 1 %0d %h", c, fifo_wr1, grant_id1, fifo_data1, req_ready1, g, word[g]);
        end
      end
      cyc();
    end
    req_valid1 = 4'b0000;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 4'b0000;
    req_valid1 = 4'b0000;
    fifo_full  = 1'b0;
    test_reset();
    test_round_robin();
    test_valid_drop();
    test_fifo_full();
    test_all_valid();
    test_mid_reset();
    test_burst_one();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
